// File: rtl/ibex_mem_arbiter.sv
// ============================================================================
// Module   : ibex_mem_arbiter
// Brief    : Round-robin sharing of one ibex req/gnt memory port between hosts,
//            with in-order response routing through an ID FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ibex_mem_arbiter #(
    parameter int NUM_HOSTS       = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_HOSTS-1:0]                  host_req_i,
    output logic [NUM_HOSTS-1:0]                  host_gnt_o,
    input  logic [NUM_HOSTS*ADDR_WIDTH-1:0]       host_addr_i,
    input  logic [NUM_HOSTS-1:0]                  host_we_i,
    input  logic [NUM_HOSTS*(DATA_WIDTH/8)-1:0]   host_be_i,
    input  logic [NUM_HOSTS*DATA_WIDTH-1:0]       host_wdata_i,
    output logic [NUM_HOSTS-1:0]                  host_rvalid_o,
    output logic [DATA_WIDTH-1:0]                 host_rdata_o,
    output logic [NUM_HOSTS-1:0]                  host_err_o,
    output logic                                  dev_req_o,
    input  logic                                  dev_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 dev_addr_o,
    output logic                                  dev_we_o,
    output logic [DATA_WIDTH/8-1:0]               dev_be_o,
    output logic [DATA_WIDTH-1:0]                 dev_wdata_o,
    input  logic                                  dev_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 dev_rdata_i,
    input  logic                                  dev_err_i,
    output logic                                  resp_unexpected_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int HW       = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam int PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW       = $clog2(MAX_OUTSTANDING + 1);

    logic [HW-1:0] r_rr_ptr;
    logic          r_lock;
    logic [HW-1:0] r_locked_id;
    logic [HW-1:0] r_ids [MAX_OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_unexpected;

    logic [HW-1:0] w_sel;
    logic [HW-1:0] w_cand;
    logic          w_found;
    logic [HW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_head  = r_ids[r_rptr];

    // A pending lock pins the address phase to the host that was refused.
    always_comb begin
        w_sel   = r_rr_ptr;
        w_cand  = r_rr_ptr;
        w_found = 1'b0;
        if (r_lock) begin
            w_sel = r_locked_id;
        end else begin
            for (int i = 0; i < NUM_HOSTS; i++) begin
                w_cand = HW'((int'(r_rr_ptr) + i) % NUM_HOSTS);
                if (!w_found && host_req_i[w_cand]) begin
                    w_sel   = w_cand;
                    w_found = 1'b1;
                end
            end
        end
    end

    assign dev_req_o = host_req_i[w_sel] & ~w_full;
    assign w_push    = dev_req_o & dev_gnt_i;
    assign w_pop     = dev_rvalid_i & ~w_empty;

    always_comb begin
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            if (w_sel == HW'(i)) begin
                dev_addr_o  = host_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                dev_we_o    = host_we_i[i];
                dev_be_o    = host_be_i[i*BE_WIDTH +: BE_WIDTH];
                dev_wdata_o = host_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            host_gnt_o[i]    = w_push && (w_sel == HW'(i));
            host_rvalid_o[i] = w_pop && (w_head == HW'(i));
            host_err_o[i]    = w_pop && (w_head == HW'(i)) && dev_err_i;
        end
    end

    assign host_rdata_o      = dev_rdata_i;
    assign resp_unexpected_o = r_unexpected;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_ids[r_wptr] <= w_sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr     <= '0;
            r_lock       <= 1'b0;
            r_locked_id  <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_unexpected <= 1'b0;
        end else begin
            if (w_push) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= (w_sel == HW'(NUM_HOSTS - 1)) ? '0 : w_sel + HW'(1);
                r_wptr   <= (r_wptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + PW'(1);
            end else if (dev_req_o) begin
                r_lock      <= 1'b1;
                r_locked_id <= w_sel;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (dev_rvalid_i && w_empty) begin
                r_unexpected <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ibex_mem_arbiter.sv
// ============================================================================
// Module   : tb_ibex_mem_arbiter
// Brief    : Directed and random checks of ibex_mem_arbiter against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    host_req;
    logic [N-1:0]    host_gnt;
    logic [N*AW-1:0] host_addr;
    logic [N-1:0]    host_we;
    logic [N*BW-1:0] host_be;
    logic [N*DW-1:0] host_wdata;
    logic [N-1:0]    host_rvalid;
    logic [DW-1:0]   host_rdata;
    logic [N-1:0]    host_err;
    logic            dev_req;
    logic            dev_gnt;
    logic [AW-1:0]   dev_addr;
    logic            dev_we;
    logic [BW-1:0]   dev_be;
    logic [DW-1:0]   dev_wdata;
    logic            dev_rvalid;
    logic [DW-1:0]   dev_rdata;
    logic            dev_err;
    logic            resp_unexpected;

    always #5 clk = ~clk;

    ibex_mem_arbiter #(
        .NUM_HOSTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr),
        .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .resp_unexpected_o(resp_unexpected)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding host IDs in grant order plus arbitration state.
    int q[$];
    int m_rr;
    bit m_lock;
    int m_lid;
    bit m_unexp;

    logic [N-1:0]  obs_gnt, obs_rvalid;
    logic          obs_req, obs_unexp;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rr = 0; m_lock = 0; m_lid = 0; m_unexp = 0;
    endtask

    // Inputs are already driven; compare at the falling edge, advance model, move past posedge.
    task automatic cycle();
        int sel;
        bit full, dreq, push, pop;
        logic [N-1:0] eg, ev, ee;
        @(negedge clk);
        sel = m_rr;
        if (m_lock) sel = m_lid;
        else begin
            for (int k = 0; k < N; k++) begin
                if (host_req[(m_rr + k) % N]) begin
                    sel = (m_rr + k) % N;
                    break;
                end
            end
        end
        full = (q.size() >= MO);
        dreq = host_req[sel] && !full;
        push = dreq && dev_gnt;
        pop  = dev_rvalid && (q.size() > 0);
        eg = '0; ev = '0; ee = '0;
        if (push) eg[sel] = 1'b1;
        if (pop) begin
            ev[q[0]] = 1'b1;
            ee[q[0]] = dev_err;
        end
        obs_gnt = host_gnt; obs_rvalid = host_rvalid; obs_req = dev_req;
        obs_unexp = resp_unexpected; obs_addr = dev_addr; obs_rdata = host_rdata;
        chk("dev_req", 64'(dev_req), 64'(dreq));
        chk("host_gnt", 64'(host_gnt), 64'(eg));
        chk("host_rvalid", 64'(host_rvalid), 64'(ev));
        chk("host_err", 64'(host_err), 64'(ee));
        chk("host_rdata", 64'(host_rdata), 64'(dev_rdata));
        chk("resp_unexpected", 64'(resp_unexpected), 64'(m_unexp));
        if (dreq) begin
            chk("dev_addr", 64'(dev_addr), 64'(host_addr[sel*AW +: AW]));
            chk("dev_we", 64'(dev_we), 64'(host_we[sel]));
            chk("dev_be", 64'(dev_be), 64'(host_be[sel*BW +: BW]));
            chk("dev_wdata", 64'(dev_wdata), 64'(host_wdata[sel*DW +: DW]));
        end
        if (dev_rvalid && q.size() == 0) m_unexp = 1;
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(sel);
            m_rr = (sel + 1) % N;
            m_lock = 0;
        end else if (dreq) begin
            m_lock = 1;
            m_lid = sel;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_req = '0; dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_err = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_dev_req", 64'(dev_req), 64'd0);
        chk("rst_unexp", 64'(resp_unexpected), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        cycle();
    endtask

    initial begin
        rst_ni = 1'b1;
        host_addr = '0; host_we = '0; host_be = '0; host_wdata = '0;
        dev_rdata = '0;
        idle_inputs();
        #1;
        do_reset();

        // Single host0 read, response two cycles later.
        host_req = 2'b01; host_addr[0 +: AW] = 32'h100; dev_gnt = 1'b1;
        cycle();
        chk("t1_gnt", 64'(obs_gnt), 64'h1);
        idle_inputs();
        cycle();
        dev_rvalid = 1'b1; dev_rdata = 32'hDEADBEEF;
        cycle();
        chk("t1_rvalid", 64'(obs_rvalid), 64'h1);
        chk("t1_rdata", 64'(obs_rdata), 64'hDEADBEEF);
        idle_inputs();
        cycle();

        // Both hosts request continuously: grants alternate, responses follow.
        do_reset();
        host_req = 2'b11; dev_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_gnt", 64'(obs_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        idle_inputs();
        dev_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_rvalid", 64'(obs_rvalid), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        idle_inputs();

        // Refused host1 holds the address phase against a later host0 request.
        do_reset();
        host_addr[0 +: AW] = 32'h100; host_addr[AW +: AW] = 32'h200;
        host_req = 2'b10;
        cycle();
        chk("t3_addr1", 64'(obs_addr), 64'h200);
        host_req = 2'b11;
        cycle();
        chk("t3_addr2", 64'(obs_addr), 64'h200);
        cycle();
        chk("t3_addr3", 64'(obs_addr), 64'h200);
        dev_gnt = 1'b1;
        cycle();
        chk("t3_gnt_h1", 64'(obs_gnt), 64'h2);
        host_req = 2'b01;
        cycle();
        chk("t3_gnt_h0", 64'(obs_gnt), 64'h1);
        idle_inputs();
        dev_rvalid = 1'b1;
        cycle();
        cycle();
        idle_inputs();

        // FIFO full blocks requests until a pop has been registered.
        do_reset();
        host_req = 2'b01; dev_gnt = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        cycle();
        chk("t4_full_req", 64'(obs_req), 64'd0);
        dev_rvalid = 1'b1;
        cycle();
        chk("t4_pop_req", 64'(obs_req), 64'd0);
        dev_rvalid = 1'b0;
        cycle();
        chk("t4_unblock_req", 64'(obs_req), 64'd1);
        idle_inputs();
        dev_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        idle_inputs();

        // Response with nothing outstanding.
        do_reset();
        dev_rvalid = 1'b1;
        cycle();
        chk("t5_no_rvalid", 64'(obs_rvalid), 64'd0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_sticky", 64'(obs_unexp), 64'd1);
        end

        // Reset with transactions in flight discards their IDs.
        do_reset();
        host_req = 2'b11; dev_gnt = 1'b1;
        cycle();
        cycle();
        do_reset();
        chk("t6_unexp_clr", 64'(obs_unexp), 64'd0);
        dev_rvalid = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        chk("t6_unexp_set", 64'(obs_unexp), 64'd1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            host_req   = N'($urandom);
            host_addr  = {$urandom, $urandom};
            host_we    = N'($urandom);
            host_be    = (N*BW)'($urandom);
            host_wdata = {$urandom, $urandom};
            dev_gnt    = ($urandom % 3) != 0;
            dev_rvalid = (q.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 32 == 0);
            dev_err    = ($urandom % 4) == 0;
            dev_rdata  = $urandom;
            cycle();
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ibex_mem_arbiter.md
Name: ibex_mem_arbiter

Overview:
- Shares one ibex memory-protocol device port (req/gnt address phase, in-order rvalid/rdata/err response phase) between NumHosts requesters.
- Typical use: instruction fetch and LSU feeding one RAM in a DV testbench, or a debug requester sharing a single-port memory.
- Arbitration is round-robin with a hold lock, so the address phase stays stable until granted.
- An ID FIFO records the host of each granted transaction and routes the in-order responses back to it.

Parameters:
NumHosts, 2, number of requesters (2..8)
AddrWidth, 32, address width
DataWidth, 32, data width; byte enable width is DataWidth/8
MaxOutstanding, 4, depth of the response-routing ID FIFO (power of 2, >=1)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
host_req_i  input  NumHosts  per-host request
host_gnt_o  output  NumHosts  per-host grant
host_addr_i  input  NumHosts*AddrWidth  per-host address
host_we_i  input  NumHosts  per-host write enable
host_be_i  input  NumHosts*DataWidth/8  per-host byte enables
host_wdata_i  input  NumHosts*DataWidth  per-host write data
host_rvalid_o  output  NumHosts  per-host response valid
host_rdata_o  output  DataWidth  read data, broadcast to all hosts
host_err_o  output  NumHosts  per-host error, qualified by host_rvalid_o
dev_req_o  output  1  device request
dev_gnt_i  input  1  device grant
dev_addr_o  output  AddrWidth  device address
dev_we_o  output  1  device write enable
dev_be_o  output  DataWidth/8  device byte enables
dev_wdata_o  output  DataWidth  device write data
dev_rvalid_i  input  1  device response valid
dev_rdata_i  input  DataWidth  device read data
dev_err_i  input  1  device error
resp_unexpected_o  output  1  sticky flag: dev_rvalid_i arrived with the ID FIFO empty

Behaviour:
- Reset (async, rst_ni low):
  - rr_ptr=0, lock=0, FIFO empty (count=0), resp_unexpected_o=0.
  - All host_gnt_o, host_rvalid_o, host_err_o and dev_req_o read 0 while no host requests.
- Request path is combinational (zero latency): sel is the winning host; dev_addr/we/be/wdata_o = host[sel] fields; dev_req_o = host_req_i[sel] && !full.
- Selection:
  - If lock=1, sel = locked_id.
  - Otherwise sel is the first requesting host scanning rr_ptr, rr_ptr+1, ... modulo NumHosts.
  - With no requests, sel = rr_ptr and dev_req_o = 0.
- host_gnt_o[sel] = dev_gnt_i && dev_req_o; all other grants are 0.
- Lock: when dev_req_o=1 and dev_gnt_i=0, set lock=1 and locked_id=sel. Clear lock on the cycle dev_req_o && dev_gnt_i. A locked host that is not yet granted cannot be preempted.
- On grant (dev_req_o && dev_gnt_i):
  - Push sel into the ID FIFO.
  - rr_ptr <= (sel+1) mod NumHosts.
- full = (count == MaxOutstanding). When full, dev_req_o is forced to 0 and no new lock forms.
  - A pop in the same cycle does not unblock; gating uses registered count.
  - Lock and full cannot coexist: a lock forms only while not full, and the next push releases it.
- Response path is combinational:
  - If dev_rvalid_i && !empty: host_rvalid_o[head]=1, host_err_o[head]=dev_err_i, pop the FIFO.
  - host_rdata_o = dev_rdata_i always.
- dev_rvalid_i with the FIFO empty: no host_rvalid_o, no pop; resp_unexpected_o <= 1 (sticky until reset).
- Simultaneous push and pop: count unchanged. Read and write pointers wrap modulo MaxOutstanding.
- A response may arrive in the same cycle as its grant only if the FIFO was non-empty; the head entry, not the new push, is popped.
- Responses are strictly in order; the block neither reorders nor drops responses.
- Reset mid-operation: in-flight IDs are discarded. Responses arriving after reset set resp_unexpected_o.

Test Plan:
1. Host0 read of addr 0x100, device grants immediately, rvalid 2 cycles later with rdata 0xDEADBEEF -> host_gnt_o=01 in the request cycle; host_rvalid_o=01 with rdata 0xDEADBEEF; other host sees no rvalid.
2. Both hosts request continuously, dev_gnt_i=1, rr_ptr=0 -> grants alternate 01,10,01,10; FIFO IDs 0,1,0,1; responses routed in that order.
3. Host1 requests, dev_gnt_i low for 3 cycles, host0 raises req on cycle 2 -> dev_addr_o stays host1's address throughout; host1 granted on cycle 4; host0 granted the next cycle.
4. MaxOutstanding=4, four grants with no rvalid -> dev_req_o=0 while a 5th request is pending; after one rvalid, dev_req_o=1 on the following cycle.
5. dev_rvalid_i pulse with the FIFO empty -> no host_rvalid_o; resp_unexpected_o=1 and held until rst_ni asserted.
6. Two outstanding transactions, then rst_ni pulsed low -> count=0, lock=0, rr_ptr=0; a later rvalid sets resp_unexpected_o.
